// File: rtl/clk_select_ctrl.sv
// Glitch-safe clock-source sequencer: gate off, hold-off, switch select, settle, gate on.
// Request comes from the register bank or, without override, from debounced DIP switches.
module clk_select_ctrl #(
    parameter int N_SRC        = 4,
    parameter int SEL_W        = 2,
    parameter int DEBOUNCE_CYC = 16,
    parameter int HOLDOFF_CYC  = 8,
    parameter int SETTLE_CYC   = 8
) (
    input  logic             usb_clk,
    input  logic             reset_n,
    input  logic [SEL_W+2:0] I_clock_reg,
    input  logic [SEL_W-1:0] I_dip_sel,
    input  logic             I_dip_out_en,
    output logic [SEL_W-1:0] O_clk_sel,
    output logic             O_clk_gate_en,
    output logic             O_clkout_en,
    output logic             O_busy,
    output logic             O_req_invalid,
    output logic [7:0]       O_switch_count
);

    localparam int DIP_W   = SEL_W + 1;
    localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam int MAX_CYC = (HOLDOFF_CYC > SETTLE_CYC) ? HOLDOFF_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLDOFF_L = CNT_W'(HOLDOFF_CYC);
    localparam logic [CNT_W-1:0] SETTLE_L  = CNT_W'(SETTLE_CYC);
    localparam logic [SEL_W:0]   N_SRC_L   = (SEL_W + 1)'(N_SRC);

    typedef enum logic [2:0] {IDLE, GATE_OFF, SWITCH, SETTLE, GATE_ON} state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [DIP_W-1:0] dip_p0, dip_p1, dip_p2, dip_db;
    logic [DB_W-1:0]  db_cnt;

    // Stage p0/p1: synchroniser; p2 holds the previous synchronised value for change detection.
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            dip_p0 <= '0;
            dip_p1 <= '0;
            dip_p2 <= '0;
            dip_db <= '0;
            db_cnt <= '0;
        end else begin
            dip_p0 <= {I_dip_out_en, I_dip_sel};
            dip_p1 <= dip_p0;
            dip_p2 <= dip_p1;
            if (dip_p1 == dip_db) begin
                db_cnt <= '0;
            end else if (dip_p1 != dip_p2) begin
                db_cnt <= DB_ONE;
            end else if (db_cnt >= DB_LAST) begin
                dip_db <= dip_p1;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_ONE;
            end
        end
    end

    logic [SEL_W-1:0] req_sel;
    logic             req_out;
    logic             req_bad;

    always_comb begin
        req_sel = I_clock_reg[0] ? I_clock_reg[SEL_W:1] : dip_db[SEL_W-1:0];
        req_out = I_clock_reg[0] ? (I_clock_reg[SEL_W+2:SEL_W+1] == 2'b01) : dip_db[SEL_W];
        req_bad = ({1'b0, req_sel} >= N_SRC_L);
    end

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [SEL_W-1:0] target, target_next;
    logic             post_reset, post_next;
    logic [SEL_W-1:0] sel_next;
    logic             gate_next;
    logic [7:0]       count_next;

    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= SETTLE;
            cnt    <= SETTLE_L;
            target <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            target <= target_next;
        end
    end

    // Counters exit on the cycle they hold 1, giving exactly N cycles in the state.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        target_next = target;
        case (state)
            IDLE: begin
                if (!req_bad && (req_sel != O_clk_sel)) begin
                    target_next = req_sel;
                    cnt_next    = HOLDOFF_L;
                    state_next  = GATE_OFF;
                end
            end
            GATE_OFF: begin
                if (cnt <= CNT_ONE) state_next = SWITCH;
                else                cnt_next   = cnt - CNT_ONE;
            end
            SWITCH: begin
                cnt_next   = SETTLE_L;
                state_next = SETTLE;
            end
            SETTLE: begin
                if (cnt <= CNT_ONE) begin
                    if (!req_bad && (req_sel != O_clk_sel)) begin
                        target_next = req_sel;
                        state_next  = SWITCH;
                    end else begin
                        state_next = GATE_ON;
                    end
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            GATE_ON:  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        sel_next   = O_clk_sel;
        gate_next  = O_clk_gate_en;
        count_next = O_switch_count;
        post_next  = post_reset;
        if (state == IDLE && state_next == GATE_OFF) gate_next = 1'b0;
        if (state == SWITCH) sel_next = target;
        if (state == GATE_ON) begin
            gate_next = 1'b1;
            post_next = 1'b0;
            if (!post_reset) count_next = sat_inc(O_switch_count);
        end
    end

    // clkout follows the gate value being registered this edge, so it is never high with the gate off.
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            O_clk_sel      <= '0;
            O_clk_gate_en  <= 1'b0;
            O_clkout_en    <= 1'b0;
            O_req_invalid  <= 1'b0;
            O_switch_count <= '0;
            post_reset     <= 1'b1;
        end else begin
            O_clk_sel      <= sel_next;
            O_clk_gate_en  <= gate_next;
            O_clkout_en    <= req_out & gate_next;
            O_req_invalid  <= req_bad;
            O_switch_count <= count_next;
            post_reset     <= post_next;
        end
    end

    assign O_busy = (state != IDLE);

endmodule

// File: tb/tb_clk_select_ctrl.sv
// Scoreboard bench for clk_select_ctrl: stimulus queues expected output changes,
// a monitor compares every observed change (value and cycle) against the queue.
module tb_clk_select_ctrl;

    typedef struct {
        int          cyc;
        logic [13:0] val;
        string       name;
    } evt_t;

    logic       usb_clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       reset3_n = 1'b1;
    logic [4:0] clock_reg = '0;
    logic [4:0] clock_reg3 = '0;
    logic [1:0] dip_sel = '0;
    logic [1:0] dip_sel3 = '0;
    logic       dip_out_en = 1'b0;
    logic       dip_out_en3 = 1'b0;

    logic [1:0] sel_a, sel_b;
    logic       gate_a, gate_b, clkout_a, clkout_b, busy_a, busy_b, inv_a, inv_b;
    logic [7:0] count_a, count_b;

    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    bit   probe = 1'b0;
    bit   done = 1'b0;
    bit   drained = 1'b0;
    bit   seen_a = 1'b0;
    bit   seen_b = 1'b0;
    logic [13:0] prev_a = '0;
    logic [13:0] prev_b = '0;
    logic [13:0] cur_a, cur_b;
    evt_t q_a[$];
    evt_t q_b[$];
    evt_t ev;

    clk_select_ctrl dut (
        .usb_clk(usb_clk), .reset_n(reset_n), .I_clock_reg(clock_reg),
        .I_dip_sel(dip_sel), .I_dip_out_en(dip_out_en),
        .O_clk_sel(sel_a), .O_clk_gate_en(gate_a), .O_clkout_en(clkout_a),
        .O_busy(busy_a), .O_req_invalid(inv_a), .O_switch_count(count_a)
    );

    clk_select_ctrl #(.N_SRC(3)) dut3 (
        .usb_clk(usb_clk), .reset_n(reset3_n), .I_clock_reg(clock_reg3),
        .I_dip_sel(dip_sel3), .I_dip_out_en(dip_out_en3),
        .O_clk_sel(sel_b), .O_clk_gate_en(gate_b), .O_clkout_en(clkout_b),
        .O_busy(busy_b), .O_req_invalid(inv_b), .O_switch_count(count_b)
    );

    always #5 usb_clk = ~usb_clk;
    always @(posedge usb_clk) cyc <= cyc + 1;

    // Packed observation: {sel[1:0], gate, clkout, busy, invalid, count[7:0]}
    function automatic logic [13:0] mk(input int sel, input bit g, input bit c,
                                       input bit b, input bit i, input int n);
        logic [1:0] s2;
        logic [7:0] n8;
        s2 = sel[1:0];
        n8 = n[7:0];
        return {s2, g, c, b, i, n8};
    endfunction

    task automatic exp_a(input int c, input logic [13:0] v, input string nm);
        q_a.push_back('{cyc: c, val: v, name: nm});
    endtask

    task automatic exp_b(input int c, input logic [13:0] v, input string nm);
        q_b.push_back('{cyc: c, val: v, name: nm});
    endtask

    always @(negedge usb_clk or posedge probe or posedge done) begin
        if (done) begin
            if (!drained) begin
                drained = 1'b1;
                n_assert++;
                if (q_a.size() != 0) begin
                    n_fail++;
                    $display("FAIL main_drain: %0d expected changes never seen, required 0 (next %s)",
                             q_a.size(), q_a[0].name);
                end
                n_assert++;
                if (q_b.size() != 0) begin
                    n_fail++;
                    $display("FAIL nsrc3_drain: %0d expected changes never seen, required 0 (next %s)",
                             q_b.size(), q_b[0].name);
                end
            end
        end else if (mon_en) begin
            cur_a = {sel_a, gate_a, clkout_a, busy_a, inv_a, count_a};
            cur_b = {sel_b, gate_b, clkout_b, busy_b, inv_b, count_b};
            if (!seen_a || cur_a !== prev_a) begin
                seen_a = 1'b1;
                prev_a = cur_a;
                n_assert++;
                if (q_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL main_unexpected: outputs %h at cycle %0d, required no change", cur_a, cyc);
                end else begin
                    ev = q_a.pop_front();
                    if (ev.cyc != cyc || cur_a !== ev.val) begin
                        n_fail++;
                        $display("FAIL main_%s: got %h at cycle %0d, required %h at cycle %0d",
                                 ev.name, cur_a, cyc, ev.val, ev.cyc);
                    end
                end
            end
            if (!seen_b || cur_b !== prev_b) begin
                seen_b = 1'b1;
                prev_b = cur_b;
                n_assert++;
                if (q_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL nsrc3_unexpected: outputs %h at cycle %0d, required no change", cur_b, cyc);
                end else begin
                    ev = q_b.pop_front();
                    if (ev.cyc != cyc || cur_b !== ev.val) begin
                        n_fail++;
                        $display("FAIL nsrc3_%s: got %h at cycle %0d, required %h at cycle %0d",
                                 ev.name, cur_b, cyc, ev.val, ev.cyc);
                    end
                end
            end
        end
    end

    initial begin
        int t, g, r;
        #2;
        reset_n  = 1'b0;
        reset3_n = 1'b0;
        repeat (3) @(negedge usb_clk);
        #1;
        t = cyc;
        exp_a(t + 1, mk(0, 0, 0, 1, 0, 0), "reset_state");
        exp_b(t + 1, mk(0, 0, 0, 1, 0, 0), "reset_state");
        mon_en = 1'b1;
        @(negedge usb_clk);

        // Release: gate comes up after the settle window, no count for the post-reset pass.
        r = cyc;
        reset_n  = 1'b1;
        reset3_n = 1'b1;
        exp_a(r + 9, mk(0, 1, 0, 0, 0, 0), "reset_release");
        exp_b(r + 9, mk(0, 1, 0, 0, 0, 0), "reset_release");
        repeat (12) @(negedge usb_clk);

        // DIP toggling faster than the debounce window, then held at 2.
        for (int k = 0; k < 4; k++) begin
            dip_sel = (k % 2 == 0) ? 2'd1 : 2'd3;
            repeat (5) @(negedge usb_clk);
        end
        t = cyc;
        dip_sel = 2'd2;
        g = t + 19;
        exp_a(g,      mk(0, 0, 0, 1, 0, 0), "dip_gate_off");
        exp_a(g + 9,  mk(2, 0, 0, 1, 0, 0), "dip_switch");
        exp_a(g + 18, mk(2, 1, 0, 0, 0, 1), "dip_gate_on");
        repeat (45) @(negedge usb_clk);

        // Register override, select 3.
        t = cyc;
        clock_reg = 5'b00111;
        g = t + 1;
        exp_a(g,      mk(2, 0, 0, 1, 0, 1), "reg3_gate_off");
        exp_a(g + 9,  mk(3, 0, 0, 1, 0, 1), "reg3_switch");
        exp_a(g + 18, mk(3, 1, 0, 0, 0, 2), "reg3_gate_on");
        repeat (25) @(negedge usb_clk);

        // Select 1, then retarget to 2 while settling: no second hold-off, one count.
        t = cyc;
        clock_reg = 5'b00011;
        g = t + 1;
        exp_a(g,     mk(3, 0, 0, 1, 0, 2), "retarget_gate_off");
        exp_a(g + 9, mk(1, 0, 0, 1, 0, 2), "retarget_first_switch");
        repeat (12) @(negedge usb_clk);
        clock_reg = 5'b00101;
        exp_a(g + 18, mk(2, 0, 0, 1, 0, 2), "retarget_second_switch");
        exp_a(g + 27, mk(2, 1, 0, 0, 0, 3), "retarget_gate_on");
        repeat (25) @(negedge usb_clk);

        // N_SRC=3 instance: out-of-range request is flagged and ignored, then a valid one switches.
        t = cyc;
        clock_reg3 = 5'b00111;
        exp_b(t + 1, mk(0, 1, 0, 0, 1, 0), "invalid_flag");
        repeat (6) @(negedge usb_clk);
        t = cyc;
        clock_reg3 = 5'b00011;
        g = t + 1;
        exp_b(g,      mk(0, 0, 0, 1, 0, 0), "valid_gate_off");
        exp_b(g + 9,  mk(1, 0, 0, 1, 0, 0), "valid_switch");
        exp_b(g + 18, mk(1, 1, 0, 0, 0, 1), "valid_gate_on");
        repeat (25) @(negedge usb_clk);

        // Output mode on: clkout follows the gate; async reset in the middle of hold-off.
        t = cyc;
        clock_reg = 5'b01101;
        exp_a(t + 1, mk(2, 1, 1, 0, 0, 3), "clkout_on");
        repeat (4) @(negedge usb_clk);
        t = cyc;
        clock_reg = 5'b01001;
        g = t + 1;
        exp_a(g, mk(2, 0, 0, 1, 0, 3), "clkout_gate_off");
        repeat (4) @(negedge usb_clk);
        exp_a(cyc, mk(0, 0, 0, 1, 0, 0), "async_reset");
        #2;
        reset_n = 1'b0;
        #1;
        probe = 1'b1;
        #1;
        probe = 1'b0;
        repeat (2) @(negedge usb_clk);
        r = cyc;
        reset_n = 1'b1;
        exp_a(r + 9, mk(0, 1, 1, 0, 0, 0), "rerelease_clkout");
        repeat (15) @(negedge usb_clk);

        done = 1'b1;
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
